// File: rtl/instrumented_adder_meter.sv
// instrumented_adder_meter: ring-oscillator edge counter and settle-time sum checker for an adder-under-test.
// Define INSTR_ADDER_SAT_EN to make count saturate instead of wrapping.
module instrumented_adder_meter #(
    parameter int WIDTH    = 32,
    parameter int CNT_W    = 32,
    parameter int SETTLE_W = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_n,
    input  logic                active,
    input  logic                start,
    input  logic                mode,
    input  logic [WIDTH-1:0]    a_in,
    input  logic [WIDTH-1:0]    b_in,
    input  logic [CNT_W-1:0]    window,
    input  logic [SETTLE_W-1:0] settle,
    output logic [WIDTH-1:0]    aut_a,
    output logic [WIDTH-1:0]    aut_b,
    output logic                ring_en,
    input  logic [WIDTH-1:0]    aut_sum,
    input  logic                aut_cout,
    input  logic                chain_in,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    count,
    output logic [WIDTH-1:0]    sum_q,
    output logic                cout_q,
    output logic                mismatch,
    output logic                overflow
);
    localparam logic [2:0] IDLE = 3'd0, LAUNCH = 3'd1, RUN = 3'd2, CAPTURE = 3'd3, DONE = 3'd4;
    localparam int TW = CNT_W > SETTLE_W ? CNT_W : SETTLE_W;
    localparam logic [CNT_W-1:0] MAX = '1;

    logic [2:0]       state;
    logic             start_q;
    logic             mode_q;
    logic [TW-1:0]    tmr;
    logic [TW-1:0]    ld;
    logic [2:0]       sync;
    logic [WIDTH:0]   golden;
    logic             miss;
    logic             inc;
    logic [CNT_W-1:0] count_inc;

    assign golden  = {1'b0, aut_a} + {1'b0, aut_b};
    assign miss    = {aut_cout, aut_sum} != golden;
    assign inc     = (state == RUN && !mode_q && sync[1] && !sync[2]) || (state == CAPTURE && mode_q && miss);
    assign ld      = mode ? TW'(settle) : TW'(window);
    assign ring_en = state == RUN && !mode_q;
    assign busy    = state == LAUNCH || state == RUN || state == CAPTURE;
    assign done    = state == DONE;
`ifdef INSTR_ADDER_SAT_EN
    assign count_inc = count == MAX ? MAX : count + 1'b1;
`else
    assign count_inc = count + 1'b1;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            mode_q   <= 1'b0;
            tmr      <= '0;
            sync     <= '0;
            aut_a    <= '0;
            aut_b    <= '0;
            count    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            mismatch <= 1'b0;
            overflow <= 1'b0;
        end else begin
            sync    <= {sync[1:0], chain_in};
            start_q <= start;
            if (!active) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (start && !start_q) begin
                        state    <= LAUNCH;
                        mode_q   <= mode;
                        aut_a    <= a_in;
                        aut_b    <= b_in;
                        tmr      <= ld == '0 ? TW'(1) : ld;
                        overflow <= 1'b0;
                        mismatch <= 1'b0;
                        if (!mode) count <= '0;
                    end
                    LAUNCH: state <= RUN;
                    RUN: if (tmr == TW'(1)) state <= CAPTURE; else tmr <= tmr - 1'b1;
                    CAPTURE: begin
                        state  <= DONE;
                        sum_q  <= aut_sum;
                        cout_q <= aut_cout;
                        if (mode_q) mismatch <= miss;
                    end
                    default: state <= IDLE;
                endcase
                // overflow flags the increment that lands on or passes the all-ones value
                if (inc) begin
                    count <= count_inc;
                    if (count >= MAX - 1'b1) overflow <= 1'b1;
                end
            end
        end
    end
endmodule
